// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues single-outstanding reads at the current
// PC, advances the PC, buffers returned words in a 2-entry queue for decode and
// applies branch redirects (flushing the queue and squashing in-flight reads).
module if_fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_cur,
  output logic        pc_wr_en,
  output logic [15:0] pc_nxt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned PC_STEP = 2;
  localparam int unsigned AW      = 16;
  localparam int unsigned CW      = 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          imem_req_q, imem_req_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic          pc_wr_en_q, pc_wr_en_d;
  logic [AW-1:0] pc_nxt_q, pc_nxt_d;

  logic [1:0][AW-1:0] ent_instr_q, ent_instr_d;
  logic [1:0][AW-1:0] ent_pc_q, ent_pc_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               instr_valid_q, instr_valid_d;
  logic [AW-1:0]      instr_q, instr_d;
  logic [AW-1:0]      instr_pc_q, instr_pc_d;

  logic push_c;
  logic pop_c;

  assign pop_c = instr_valid_q & instr_ready;

  // Fetch FSM: redirect wins over issue/ack; occupancy checked before any pop.
  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    pc_wr_en_d  = 1'b0;
    pc_nxt_d    = pc_nxt_q;
    push_c      = 1'b0;
    if (redirect) begin
      pc_wr_en_d = 1'b1;
      pc_nxt_d   = redirect_addr;
      case (state_q)
        S_WAIT: begin
          if (imem_ack) begin
            state_d    = S_IDLE;
            imem_req_d = 1'b0;
          end else begin
            state_d = S_SQUASH;
          end
        end
        S_SQUASH: begin
          if (imem_ack) begin
            state_d    = S_IDLE;
            imem_req_d = 1'b0;
          end
        end
        S_IDLE:  ;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q < CW'(DEPTH)) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_cur;
            pc_wr_en_d  = 1'b1;
            pc_nxt_d    = pc_cur + AW'(PC_STEP);
            state_d     = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_ack) begin
            push_c     = 1'b1;
            imem_req_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
        S_SQUASH: begin
          if (imem_ack) begin
            imem_req_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Queue next state; head outputs are registered from the post-update head.
  always_comb begin
    ent_instr_d = ent_instr_q;
    ent_pc_d    = ent_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (redirect) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        ent_instr_d[wr_ptr_q] = imem_rdata;
        ent_pc_d[wr_ptr_q]    = imem_addr_q;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    instr_valid_d = (count_d != '0);
    instr_d       = ent_instr_d[rd_ptr_d];
    instr_pc_d    = ent_pc_d[rd_ptr_d];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      imem_req_q    <= 1'b0;
      imem_addr_q   <= '0;
      pc_wr_en_q    <= 1'b0;
      pc_nxt_q      <= '0;
      ent_instr_q   <= '0;
      ent_pc_q      <= '0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      imem_req_q    <= imem_req_d;
      imem_addr_q   <= imem_addr_d;
      pc_wr_en_q    <= pc_wr_en_d;
      pc_nxt_q      <= pc_nxt_d;
      ent_instr_q   <= ent_instr_d;
      ent_pc_q      <= ent_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

  assign pc_wr_en    = pc_wr_en_q;
  assign pc_nxt      = pc_nxt_q;
  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed cycle table plus fill/drain and reset sequences.
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc_cur;
  logic        pc_wr_en;
  logic [15:0] pc_nxt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;

  int n_tests;
  int n_fail;

  if_fetch_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_cur       (pc_cur),
    .pc_wr_en     (pc_wr_en),
    .pc_nxt       (pc_nxt),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model: negedge-loaded from pc_nxt.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) pc_cur <= 16'h0000;
    else if (pc_wr_en) pc_cur <= pc_nxt;
  end

  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        redir;
    logic [15:0] raddr;
    logic        ready;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_wr;
    logic [15:0] e_nxt;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc_wr_en"},    16'(pc_wr_en),    16'h0);
    chk({tag, "_pc_nxt"},      pc_nxt,           16'h0);
    chk({tag, "_imem_req"},    16'(imem_req),    16'h0);
    chk({tag, "_imem_addr"},   imem_addr,        16'h0);
    chk({tag, "_instr_valid"}, 16'(instr_valid), 16'h0);
    chk({tag, "_instr"},       instr,            16'h0);
    chk({tag, "_instr_pc"},    instr_pc,         16'h0);
  endtask

  initial begin
    int pulses;
    int pops;
    logic [15:0] exp_pc;
    n_tests = 0;
    n_fail  = 0;

    tbl[0]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{1'b1, 16'hA001, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'hA001, 16'h0000};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h0004, 1'b1, 16'hA001, 16'h0000};
    tbl[3]  = '{1'b1, 16'hB002, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0, 16'h0004, 1'b1, 16'hA001, 16'h0000};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0, 16'h0004, 1'b1, 16'hA001, 16'h0000};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b0, 16'h0004, 1'b1, 16'hB002, 16'h0002};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b1, 16'h0006, 1'b1, 16'hB002, 16'h0002};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0004, 1'b0, 16'h0006, 1'b1, 16'hB002, 16'h0002};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 16'h0100, 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000};
    tbl[9]  = '{1'b1, 16'hDEAD, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0004, 1'b0, 16'h0100, 1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b1, 16'h0102, 1'b0, 16'h0000, 16'h0000};
    tbl[11] = '{1'b1, 16'hC100, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 16'h0102, 1'b1, 16'hC100, 16'h0100};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0102, 1'b1, 16'h0104, 1'b0, 16'h0000, 16'h0000};
    tbl[13] = '{1'b1, 16'hC102, 1'b1, 16'hFFFE, 1'b1, 1'b0, 16'h0102, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000};
    tbl[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    tbl[15] = '{1'b1, 16'hE0FE, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFE, 1'b0, 16'h0000, 1'b1, 16'hE0FE, 16'hFFFE};
    tbl[16] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0002, 1'b1, 16'hE0FE, 16'hFFFE};
    tbl[17] = '{1'b1, 16'hE000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'hE000, 16'h0000};
    tbl[18] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000};

    // Reset values
    apply_reset();
    chk_reset_vals("reset");
    chk("reset_pc_cur", pc_cur, 16'h0000);

    // Directed cycle table: fill, block, redirect in WAIT, redirect with ack, wrap
    for (int i = 0; i < NV; i++) begin
      imem_ack      = tbl[i].ack;
      imem_rdata    = tbl[i].rdata;
      redirect      = tbl[i].redir;
      redirect_addr = tbl[i].raddr;
      instr_ready   = tbl[i].ready;
      step();
      chk($sformatf("v%0d_imem_req", i),    16'(imem_req),    16'(tbl[i].e_req));
      chk($sformatf("v%0d_imem_addr", i),   imem_addr,        tbl[i].e_addr);
      chk($sformatf("v%0d_pc_wr_en", i),    16'(pc_wr_en),    16'(tbl[i].e_wr));
      chk($sformatf("v%0d_pc_nxt", i),      pc_nxt,           tbl[i].e_nxt);
      chk($sformatf("v%0d_instr_valid", i), 16'(instr_valid), 16'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_instr", i),    instr,    tbl[i].e_instr);
        chk($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
      end
    end

    // Asynchronous reset while a request is outstanding
    imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    chk("pre_rst_imem_req", 16'(imem_req), 16'h1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    #3 rst_n = 1'b1;
    @(negedge clk);
    step();
    chk("post_rst_issue_addr", imem_addr,      16'h0000);
    chk("post_rst_issue_req",  16'(imem_req),  16'h1);
    chk("post_rst_issue_nxt",  pc_nxt,         16'h0002);

    // Fill with decode stalled: zero-latency memory, ready low for 10 cycles
    apply_reset();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      imem_ack    = imem_req;
      imem_rdata  = imem_addr ^ 16'h5A5A;
      instr_ready = 1'b0;
      step();
      if (pc_wr_en) pulses++;
    end
    chk("fill_pulses",      16'(pulses),      16'd2);
    chk("fill_imem_req",    16'(imem_req),    16'h0);
    chk("fill_instr_valid", 16'(instr_valid), 16'h1);
    chk("fill_head_pc",     instr_pc,         16'h0000);

    // Drain in order, then fetch resumes at 0004
    pops = 0;
    exp_pc = 16'h0000;
    for (int c = 0; c < 40 && pops < 3; c++) begin
      imem_ack    = imem_req;
      imem_rdata  = imem_addr ^ 16'h5A5A;
      instr_ready = 1'b1;
      if (instr_valid) begin
        chk($sformatf("drain%0d_pc", pops),    instr_pc, exp_pc);
        chk($sformatf("drain%0d_instr", pops), instr,    exp_pc ^ 16'h5A5A);
        pops++;
        exp_pc = exp_pc + 16'd2;
      end
      step();
    end
    chk("drain_pop_count", 16'(pops), 16'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller on the read side of the program counter. It consumes the PC value and drives the PC's write-enable and next-value inputs. It issues single-outstanding reads to a variable-latency instruction memory and buffers returned instructions in a 2-entry queue for decode. It also applies branch redirects, squashing any in-flight fetch.

## Interface
- DEPTH, 2, instruction queue entries (fixed; pointer logic sized for 2)
- PC_STEP, 2, byte increment per sequential fetch
- clk  input  1  core clock; this block is posedge, the PC register is negedge
- rst_n  input  1  reset, asynchronous, active-low
- pc_cur  input  16  current PC register output
- pc_wr_en  output  1  one-cycle pulse; PC loads pc_nxt on the following negedge
- pc_nxt  output  16  value for the PC to load
- imem_req  output  1  read request, held until imem_ack
- imem_addr  output  16  read address, stable while imem_req=1
- imem_ack  input  1  one-cycle response strobe, valid only while imem_req=1
- imem_rdata  input  16  instruction word, valid with imem_ack
- redirect  input  1  branch/jump taken, one-cycle pulse
- redirect_addr  input  16  target address
- instr_valid  output  1  queue head valid
- instr  output  16  queue head instruction
- instr_pc  output  16  address of queue head
- instr_ready  input  1  decode accepts head when instr_valid & instr_ready

## Operation
- States:
  - IDLE: no request outstanding.
  - WAIT: request outstanding.
  - SQUASH: request outstanding whose data will be discarded.
- Issue (IDLE, no redirect, count < DEPTH, where count is the queue occupancy before this cycle's pop):
  - imem_req<=1; imem_addr<=pc_cur.
  - pc_wr_en<=1; pc_nxt<=pc_cur+PC_STEP.
  - Go to WAIT.
- WAIT, imem_ack=1, no redirect:
  - Push {imem_rdata, imem_addr}; imem_req<=0; go to IDLE.
  - A push is guaranteed to have space because issue reserved it.
- Redirect (any state, highest priority):
  - pc_wr_en<=1; pc_nxt<=redirect_addr.
  - Queue flushed: count=0, and any same-cycle pop or push is ignored.
  - No issue this cycle.
  - WAIT without ack → SQUASH, imem_req stays 1.
  - WAIT with ack in the same cycle → data dropped, imem_req<=0, go to IDLE.
  - IDLE or SQUASH → state unchanged, except SQUASH with ack → IDLE.
- SQUASH with imem_ack: discard data; imem_req<=0; go to IDLE; no push.
- Pop: on instr_valid & instr_ready; head advances.
- Simultaneous push and pop: both occur, count unchanged.
- Arithmetic: pc_cur+PC_STEP is 16-bit modulo; 16'hFFFE+2 → 16'h0000.
- Queue: 2-entry circular buffer with 1-bit pointers and a 2-bit count.

## Timing
- Reset values: pc_wr_en=0, pc_nxt=0, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0; state IDLE; queue empty.
- All outputs registered at posedge; instr/instr_pc come from the queue head register.
- pc_wr_en is high for exactly one cycle per issue or redirect, and is never high two cycles in a row from issue alone.
- PC updates on the negedge inside the pulse cycle, so pc_cur is already updated at the next posedge.
- Zero-latency memory (ack in the first cycle imem_req=1): minimum 2 cycles per fetch (issue, ack).
- Data is visible at instr_valid on the cycle after imem_ack, giving a 3-cycle issue-to-decode minimum.
- Issue is blocked when count==DEPTH. With a pop in the same cycle, issue waits one cycle (count is evaluated pre-pop).
- Reset mid-request: imem_req drops immediately (asynchronous). Memory must treat a deasserted imem_req as a cancel.

## Test plan
- Reset then run, memory with 1-cycle ack latency, instr_ready=1:
  - PC sequence 0000,0002,0004.
  - instr_pc matches each address; one pc_wr_en pulse per fetch.
- instr_ready=0 for 10 cycles:
  - Exactly 2 entries fill and imem_req stays 0.
  - On ready=1 the entries drain in order, then fetch resumes at 0004.
- Redirect to 0x0100 while WAIT with ack 3 cycles later:
  - State SQUASH; the late data is not pushed.
  - Next issue uses imem_addr=0100 and the queue is empty after the redirect.
- Redirect in the same cycle as imem_ack:
  - Data dropped; IDLE; pc_nxt=redirect_addr.
  - Issue at the target on the next cycle.
- pc_cur=FFFE issue:
  - pc_nxt=0000; the following fetch uses imem_addr=0000.
- Assert rst_n=0 mid-WAIT:
  - All outputs return to reset values asynchronously.
  - After release the first issue uses pc_cur=0000.
